// File: rtl/spi_master_nbit_pkg.sv
// ---------------------------------------------------------------------------
// spi_master_nbit_pkg
// Shared definitions for the parametrised SPI master and later SPI blocks:
//   - spi_state_e : transfer FSM state encoding (IDLE/SETUP/SHIFT/HOLD/DONE)
//   - MODE0..MODE3: SPI mode constants encoded as {CPOL, CPHA}
//   - cs_width()  : width of a chip-select index for a given line count
// ---------------------------------------------------------------------------
package spi_master_nbit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // A single chip select still needs a 1-bit index port.
    function automatic int cs_width(input int num_cs);
        return (num_cs > 1) ? $clog2(num_cs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_nbit_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_master_nbit_clk_gen
// SCLK half-period timer. While en_i is high it emits a one-clk half_tick_o
// every CLK_DIV cycles; dropping en_i returns the counter to zero so every
// transfer starts from a full half-period.
// Ports:
//   clk         in  system clock
//   rst_n       in  asynchronous active-low reset
//   en_i        in  count enable (high while a transfer is in flight)
//   half_tick_o out one-cycle pulse on the last cycle of each half-period
// ---------------------------------------------------------------------------
module spi_master_nbit_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic half_tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last;

    assign last        = (cnt_q == CNT_LAST);
    assign half_tick_o = en_i && last;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_nbit.sv
// ---------------------------------------------------------------------------
// spi_master_nbit
// Full-duplex SPI master with configurable word width, SCLK divider,
// CPOL/CPHA, bit order and number of chip selects. One word per start:
// din is shifted out on MOSI while MISO is assembled into dout.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   start   in  transfer request, accepted in IDLE or in the DONE cycle
//   din     in  [DATA_W] transmit word, latched on the accepted start
//   cs_sel  in  [CS_W]   chip-select index, latched on the accepted start
//   MISO    in  serial data from the slave
//   SCLK    out serial clock (idles at CPOL)
//   MOSI    out serial data to the slave
//   CS_N    out [NUM_CS] active-low chip selects
//   dout    out [DATA_W] received word, valid from done until the next done
//   done    out one-cycle end-of-transfer pulse
//   busy    out high from the accepted start up to (not including) done
// ---------------------------------------------------------------------------
module spi_master_nbit
    import spi_master_nbit_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 4,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1,
    parameter int NUM_CS    = 1,
    localparam int CS_W     = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              MISO,
    output logic              SCLK,
    output logic              MOSI,
    output logic [NUM_CS-1:0] CS_N,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy
);

    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [1:0] SPI_MODE  = {CPOL != 0, CPHA != 0};
    localparam logic       SCLK_IDLE = (CPOL != 0);
    // CPHA=0 modes sample on the leading edge and shift on the trailing one;
    // CPHA=1 modes do the reverse.
    localparam logic SAMPLE_LEAD = (SPI_MODE == MODE0) || (SPI_MODE == MODE2);
    localparam logic SHIFT_LEAD  = (SPI_MODE == MODE1) || (SPI_MODE == MODE3);

    // Bit-order helpers: the same ordering drives TX and RX so dout bit i
    // lines up with din bit i.
    function automatic logic tx_head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w,
                                                   input logic              b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    // Out-of-range indices leave every line deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    spi_state_e        state_q, state_d;
    logic              phase_q, phase_d;      // 0: leading half, 1: trailing half
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              half_tick;
    logic              tick_en;

    assign tick_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) ||
                     (state_q == ST_HOLD);

    spi_master_nbit_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (tick_en),
        .half_tick_o (half_tick)
    );

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        dout_d  = dout_q;

        unique case (state_q)
            // DONE shares the accept path so back-to-back words leave CS_N
            // high for exactly the one DONE cycle.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_SETUP;
                    tx_d    = din;
                    mosi_d  = tx_head(din);
                    cs_n_d  = cs_decode(cs_sel);
                end
            end

            ST_SETUP: begin
                sclk_d = SCLK_IDLE;
                if (half_tick) begin
                    state_d = ST_SHIFT;
                    phase_d = 1'b0;
                    bit_d   = '0;
                    sclk_d  = ~SCLK_IDLE;
                    // First leading edge: CPHA=1 re-drives bit 0, so only
                    // the CPHA=0 sample happens here.
                    if (SAMPLE_LEAD) begin
                        rx_d = rx_shift(rx_q, MISO);
                    end
                end
            end

            ST_SHIFT: begin
                if (half_tick) begin
                    if (!phase_q) begin
                        // Trailing SCLK edge.
                        phase_d = 1'b1;
                        sclk_d  = SCLK_IDLE;
                        if (SHIFT_LEAD) begin
                            rx_d = rx_shift(rx_q, MISO);
                        end else if (bit_q != LAST_BIT) begin
                            tx_d   = tx_shift(tx_q);
                            mosi_d = tx_head(tx_shift(tx_q));
                        end
                    end else if (bit_q == LAST_BIT) begin
                        state_d = ST_HOLD;
                    end else begin
                        // Leading SCLK edge of the next bit.
                        bit_d   = bit_q + 1'b1;
                        phase_d = 1'b0;
                        sclk_d  = ~SCLK_IDLE;
                        if (SAMPLE_LEAD) begin
                            rx_d = rx_shift(rx_q, MISO);
                        end else begin
                            tx_d   = tx_shift(tx_q);
                            mosi_d = tx_head(tx_shift(tx_q));
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (half_tick) begin
                    state_d = ST_DONE;
                    cs_n_d  = '1;
                    dout_d  = rx_q;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SETUP) || (state_d == ST_SHIFT) ||
                 (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            phase_q <= 1'b0;
            bit_q   <= '0;
            mosi_q  <= 1'b0;
            sclk_q  <= SCLK_IDLE;
            cs_n_q  <= '1;
            dout_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            mosi_q  <= mosi_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Shift registers carry data only; every word overwrites them fully.
    always_ff @(posedge clk) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign CS_N = cs_n_q;
    assign dout = dout_q;
    assign done = done_q;
    assign busy = busy_q;

endmodule
